modbus_req_ctrl: RTL and testbench
==================================

# modbus_req_ctrl

Request sequencer for the Modbus RTU slave. It sits between the receive frame parser and two downstream resources: the holding-register bus and the response byte stream that feeds the transmit framer.

For each validated request it:
- decodes the function code;
- range-checks the address and quantity;
- performs the register reads or write;
- emits either the normal response payload or an exception response payload.

The transmit framer appends the CRC; this block never emits CRC bytes.

## Interface
Parameters:
- REG_BASE, 16'h0000, first implemented holding-register address
- REG_NUM, 16, number of implemented registers (1..256)
- MAX_QTY, 8, maximum registers per 0x03 read (1..125)
- ACK_TIMEOUT, 255, cycles to wait for reg_ack before device failure

Ports:
- clk_in, input, 1, system clock
- rst_n_in, input, 1, asynchronous active-low reset
- dev_addr, input, 8, slave address, echoed as the first response byte
- rx_message_done, input, 1, one-cycle pulse: func_code/addr/data valid and CRC-checked
- func_code, input, 8, request function code
- addr, input, 16, starting register address
- data, input, 16, quantity (0x03) or write value (0x06)
- req_busy, output, 1, high from capture until the last response byte is accepted
- req_drop, output, 1, one-cycle pulse when rx_message_done arrives while req_busy
- reg_req, output, 1, register access request, held until ack
- reg_we, output, 1, 1 = write, 0 = read; stable while reg_req
- reg_addr, output, 16, absolute register address
- reg_wdata, output, 16, write data
- reg_rdata, input, 16, read data, valid in the reg_ack cycle
- reg_ack, input, 1, one-cycle access completion
- tx_data, output, 8, response byte
- tx_vld, output, 1, byte valid
- tx_rdy, input, 1, downstream accepts when tx_vld && tx_rdy
- tx_last, output, 1, qualifies the final payload byte
- exc_code, output, 8, last exception code issued (0 = none), sticky until the next capture

## Operation
States: IDLE, CHECK, REG_ACC, TX_RSP, TX_EXC.

IDLE
- On rx_message_done: capture func_code/addr/data, clear exc_code, assert req_busy, go to CHECK.

CHECK (1 cycle)
- func_code not 0x03/0x06 → exception 0x01.
- 0x03:
  - data==0 or data>MAX_QTY → exception 0x03.
  - else addr<REG_BASE or (addr−REG_BASE)+data > REG_NUM → exception 0x02.
  - Arithmetic is done at 17 bits; no wrap.
- 0x06: addr<REG_BASE or addr−REG_BASE ≥ REG_NUM → exception 0x02.
- Otherwise go to REG_ACC.

REG_ACC
- 0x03: read `data` registers at addr, addr+1, … into an internal MAX_QTY×16 buffer.
- 0x06: one write of data to addr.
- Each access runs until reg_ack. If a wait exceeds ACK_TIMEOUT cycles → drop reg_req, exception 0x04. Buffered data is discarded and no partial response is sent.

TX_RSP
- 0x03 payload: dev_addr, 0x03, 2×qty, then for each register: hi byte, lo byte.
- 0x06 payload: dev_addr, 0x06, addr hi, addr lo, data hi, data lo.

TX_EXC
- Payload: dev_addr, func_code|0x80, exc_code.

Completion
- After the tx_last byte is accepted → IDLE, req_busy low.

Any rx_message_done outside IDLE → req_drop pulse; the request is otherwise ignored.

## Timing
- Reset: all outputs 0; state IDLE; buffer contents don't-care.
- rx_message_done in cycle N → req_busy high at N+1; CHECK occupies N+1.
- First reg_req, or first tx_vld for an exception, is high at N+2.

Register access:
- reg_req, reg_we, reg_addr and reg_wdata are registered and stable while reg_req is high.
- reg_req drops in the cycle after reg_ack.
- The next request asserts no earlier than one cycle after that, so reg_req is low for at least one cycle between accesses.
- Timeout counting starts in the first reg_req cycle. Reaching ACK_TIMEOUT cycles without ack → reg_req low the next cycle.
- A reg_ack arriving in the same cycle the timeout fires counts as success.

Transmit handshake:
- tx_data and tx_last must not change while tx_vld && !tx_rdy.
- Consecutive bytes go out back-to-back when tx_rdy stays high (one byte per cycle).
- tx_vld drops the cycle after the tx_last byte is accepted; req_busy drops in the same cycle.

Reset mid-operation aborts immediately; no byte is completed.

## Configuration
- MODBUS_EXCEPTION_EN defined: exception responses are emitted as specified.
- MODBUS_EXCEPTION_EN undefined:
  - exception conditions still set exc_code;
  - no tx bytes are emitted;
  - the block returns to IDLE the cycle after the error is detected, and req_busy drops then.

## Structure
- Shared package modbus_pkg:
  - function code constants FC_READ_HOLD=8'h03, FC_WRITE_SINGLE=8'h06;
  - exception constants EXC_ILL_FUNC=1, EXC_ILL_ADDR=2, EXC_ILL_VAL=3, EXC_DEV_FAIL=4;
  - the state encoding.
- One natural sub-module, modbus_rsp_buf: the MAX_QTY×16 read buffer with write pointer and byte-serialising read pointer (hi then lo).

## Test plan
- Read: REG_BASE=0, func 0x03, addr 0x0002, qty 2, rdata 0x1234/0xABCD → reg_addr 2,3 read; bytes dev_addr,03,04,12,34,AB,CD; tx_last on CD.
- Write with slow tx: func 0x06, addr 0x0005, data 0xBEEF, ack after 3 cycles, tx_rdy toggling → one write reg_we=1; echo dev_addr,06,00,05,BE,EF with tx_data held while stalled.
- Illegal function and quantity: func 0x10 → dev_addr,90,01, exc_code 0x01. Func 0x03 with qty 0 or qty 9 (MAX_QTY 8) → dev_addr,83,03, no reg_req.
- Address range: REG_NUM 16, read addr 15 qty 2 → dev_addr,83,02. Addr 0xFFFF qty 2 also → exception 02 (no 16-bit wrap).
- Timeout: reg_ack withheld → reg_req drops after 255 cycles; dev_addr,83,04. With macro undefined: no tx_vld, exc_code 0x04, req_busy low.
- Busy and reset: second rx_message_done during TX_RSP → req_drop pulse, current response unaffected. rst_n_in low mid-transfer → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared Modbus RTU constants and the request sequencer state encoding.
// Pure declarations: no latency, no flow control.
package modbus_pkg;

  localparam logic [7:0] FC_READ_HOLD    = 8'h03;
  localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;

  localparam logic [7:0] EXC_ILL_FUNC = 8'h01;
  localparam logic [7:0] EXC_ILL_ADDR = 8'h02;
  localparam logic [7:0] EXC_ILL_VAL  = 8'h03;
  localparam logic [7:0] EXC_DEV_FAIL = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REG_ACC,
    ST_TX_RSP,
    ST_TX_EXC
  } state_t;

endpackage

// File: rtl/modbus_rsp_buf.sv
// Read-data buffer: words written in order, read back as bytes, hi byte first.
// Read byte is combinational from the read pointer; clr rewinds both pointers.
module modbus_rsp_buf
  import modbus_pkg::*;
#(
  parameter int MAX_QTY = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_adv,
  output logic [7:0]  rd_byte
);

  localparam int PW = $clog2(MAX_QTY + 1);

  logic [15:0]   mem [0:(1 << PW) - 1];
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [15:0]   rd_word;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_word = mem[rd_ptr[PW:1]];
  assign rd_byte = rd_ptr[0] ? rd_word[7:0] : rd_word[15:8];

endmodule

// File: rtl/modbus_req_ctrl.sv
// Modbus RTU request sequencer (0x03/0x06): check, register access, response bytes; reg_req at N+2 after rx_message_done.
// tx bytes held while tx_rdy low; exception payloads only with MODBUS_EXCEPTION_EN defined.
module modbus_req_ctrl
  import modbus_pkg::*;
#(
  parameter logic [15:0] REG_BASE    = 16'h0000,
  parameter int          REG_NUM     = 16,
  parameter int          MAX_QTY     = 8,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  dev_addr,
  input  logic        rx_message_done,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic        req_busy,
  output logic        req_drop,
  output logic        reg_req,
  output logic        reg_we,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        tx_last,
  output logic [7:0]  exc_code
);

  state_t      state, state_nxt;
  logic [7:0]  func_q, func_nxt;
  logic [15:0] addr_q, addr_nxt, data_q, data_nxt;
  logic [15:0] acc_q, acc_nxt, cnt_q, cnt_nxt;
  logic [7:0]  idx_q, idx_nxt, nidx, last_idx, rsp_byte, chk_exc;
  logic        req_drop_nxt, reg_req_nxt, reg_we_nxt, tx_vld_nxt, tx_last_nxt;
  logic [15:0] reg_addr_nxt, reg_wdata_nxt;
  logic [7:0]  tx_data_nxt, exc_nxt;
  logic        buf_clr, buf_wr, buf_adv, raise_exc, is_write;
  logic [7:0]  buf_byte;
  logic [16:0] off17, end17;

  modbus_rsp_buf #(.MAX_QTY(MAX_QTY)) u_buf (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (reg_rdata),
    .rd_adv  (buf_adv),
    .rd_byte (buf_byte)
  );

  assign req_busy = (state != ST_IDLE);
  assign is_write = (func_q == FC_WRITE_SINGLE);
  assign nidx     = idx_q + 8'd1;

  // 17-bit range arithmetic so addr+qty cannot wrap past 0xFFFF.
  always_comb begin
    off17   = {1'b0, addr_q} - {1'b0, REG_BASE};
    end17   = off17 + {1'b0, data_q};
    chk_exc = 8'h00;
    if (func_q != FC_READ_HOLD && func_q != FC_WRITE_SINGLE)
      chk_exc = EXC_ILL_FUNC;
    else if (func_q == FC_READ_HOLD) begin
      if (data_q == 16'h0 || data_q > 16'(MAX_QTY))
        chk_exc = EXC_ILL_VAL;
      else if (addr_q < REG_BASE || end17 > 17'(REG_NUM))
        chk_exc = EXC_ILL_ADDR;
    end else if (addr_q < REG_BASE || off17 >= 17'(REG_NUM))
      chk_exc = EXC_ILL_ADDR;
  end

  // Byte that follows the one currently on tx_data.
  always_comb begin
    rsp_byte = 8'h00;
    last_idx = 8'd5;
    if (state == ST_TX_EXC) begin
      last_idx = 8'd2;
      rsp_byte = (nidx == 8'd1) ? (func_q | 8'h80) : exc_code;
    end else if (is_write) begin
      case (nidx)
        8'd1:    rsp_byte = FC_WRITE_SINGLE;
        8'd2:    rsp_byte = addr_q[15:8];
        8'd3:    rsp_byte = addr_q[7:0];
        8'd4:    rsp_byte = data_q[15:8];
        default: rsp_byte = data_q[7:0];
      endcase
    end else begin
      last_idx = {data_q[6:0], 1'b0} + 8'd2;
      case (nidx)
        8'd1:    rsp_byte = FC_READ_HOLD;
        8'd2:    rsp_byte = {data_q[6:0], 1'b0};
        default: rsp_byte = buf_byte;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    func_nxt      = func_q;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    acc_nxt       = acc_q;
    cnt_nxt       = cnt_q;
    idx_nxt       = idx_q;
    reg_req_nxt   = reg_req;
    reg_we_nxt    = reg_we;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    tx_data_nxt   = tx_data;
    tx_vld_nxt    = tx_vld;
    tx_last_nxt   = tx_last;
    exc_nxt       = exc_code;
    req_drop_nxt  = rx_message_done && (state != ST_IDLE);
    buf_clr       = 1'b0;
    buf_wr        = 1'b0;
    buf_adv       = 1'b0;
    raise_exc     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_message_done) begin
          func_nxt  = func_code;
          addr_nxt  = addr;
          data_nxt  = data;
          exc_nxt   = 8'h00;
          buf_clr   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_exc != 8'h00) begin
          exc_nxt   = chk_exc;
          raise_exc = 1'b1;
        end else begin
          state_nxt     = ST_REG_ACC;
          reg_req_nxt   = 1'b1;
          reg_we_nxt    = is_write;
          reg_addr_nxt  = addr_q;
          reg_wdata_nxt = is_write ? data_q : 16'h0000;
          acc_nxt       = 16'h0000;
          cnt_nxt       = 16'h0000;
        end
      end
      ST_REG_ACC: begin
        if (reg_req) begin
          if (reg_ack) begin
            reg_req_nxt = 1'b0;
            acc_nxt     = acc_q + 16'd1;
            buf_wr      = !reg_we;
            if (reg_we || (acc_q + 16'd1 == data_q)) begin
              state_nxt   = ST_TX_RSP;
              tx_vld_nxt  = 1'b1;
              tx_data_nxt = dev_addr;
              tx_last_nxt = 1'b0;
              idx_nxt     = 8'd0;
            end
          end else if (cnt_q + 16'd1 >= 16'(ACK_TIMEOUT)) begin
            reg_req_nxt = 1'b0;
            exc_nxt     = EXC_DEV_FAIL;
            raise_exc   = 1'b1;
          end else begin
            cnt_nxt = cnt_q + 16'd1;
          end
        end else begin
          reg_req_nxt  = 1'b1;
          reg_addr_nxt = addr_q + acc_q;
          cnt_nxt      = 16'h0000;
        end
      end
      ST_TX_RSP, ST_TX_EXC: begin
        if (tx_vld && tx_rdy) begin
          if (tx_last) begin
            tx_vld_nxt  = 1'b0;
            tx_last_nxt = 1'b0;
            state_nxt   = ST_IDLE;
          end else begin
            idx_nxt     = nidx;
            tx_data_nxt = rsp_byte;
            tx_last_nxt = (nidx == last_idx);
            buf_adv     = (state == ST_TX_RSP) && !is_write && (nidx >= 8'd3);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (raise_exc) begin
`ifdef MODBUS_EXCEPTION_EN
      state_nxt   = ST_TX_EXC;
      tx_vld_nxt  = 1'b1;
      tx_data_nxt = dev_addr;
      tx_last_nxt = 1'b0;
      idx_nxt     = 8'd0;
`else
      state_nxt   = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      func_q    <= 8'h00;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      acc_q     <= 16'h0000;
      cnt_q     <= 16'h0000;
      idx_q     <= 8'h00;
      req_drop  <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 16'h0000;
      reg_wdata <= 16'h0000;
      tx_data   <= 8'h00;
      tx_vld    <= 1'b0;
      tx_last   <= 1'b0;
      exc_code  <= 8'h00;
    end else begin
      state     <= state_nxt;
      func_q    <= func_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      acc_q     <= acc_nxt;
      cnt_q     <= cnt_nxt;
      idx_q     <= idx_nxt;
      req_drop  <= req_drop_nxt;
      reg_req   <= reg_req_nxt;
      reg_we    <= reg_we_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      tx_data   <= tx_data_nxt;
      tx_vld    <= tx_vld_nxt;
      tx_last   <= tx_last_nxt;
      exc_code  <= exc_nxt;
    end
  end

endmodule

// File: tb/tb_modbus_req_ctrl.sv
// Self-checking bench for modbus_req_ctrl: directed and random requests against a byte-level reference model.
module tb_modbus_req_ctrl;

  localparam int MAX_QTY = 8;
  localparam int REG_NUM = 16;
  localparam int BASE    = 0;
  localparam int ACK_TO  = 255;

  logic        clk_in, rst_n_in, rx_message_done, tx_rdy, reg_ack, tx_vld, tx_last;
  logic [7:0]  dev_addr, func_code, tx_data, exc_code;
  logic [15:0] addr, data, reg_rdata, reg_addr, reg_wdata;
  logic        req_busy, req_drop, reg_req, reg_we;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  got_q[$];
  logic        got_last_q[$];
  logic [32:0] acc_log[$];
  int          last_run, run, tx_hold_err, reg_hold_err, ack_drop_err;
  bit          rdy_rand, ack_en;
  int          ack_dly;

  logic        stall_p, l_p, rq_p, ack_p, we_p;
  logic [7:0]  d_p;
  logic [15:0] a_p, wd_p;
  int          wcnt, cur_dly;

  modbus_req_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .dev_addr(dev_addr),
    .rx_message_done(rx_message_done), .func_code(func_code), .addr(addr), .data(data),
    .req_busy(req_busy), .req_drop(req_drop), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_last(tx_last), .exc_code(exc_code)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream models: tx sink with optional random stalls, register slave with configurable ack delay.
  initial begin
    tx_rdy = 1'b0; reg_ack = 1'b0; reg_rdata = 16'h0;
    stall_p = 0; l_p = 0; rq_p = 0; ack_p = 0; we_p = 0; d_p = 0; a_p = 0; wd_p = 0;
    wcnt = 0; cur_dly = 1; run = 0; last_run = 0;
    tx_hold_err = 0; reg_hold_err = 0; ack_drop_err = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        tx_rdy = 1'b0; reg_ack = 1'b0; stall_p = 0; rq_p = 0; ack_p = 0; run = 0;
      end else begin
        if (stall_p && (tx_vld !== 1'b1 || tx_data !== d_p || tx_last !== l_p)) tx_hold_err++;
        tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_vld && tx_rdy) begin
          got_q.push_back(tx_data);
          got_last_q.push_back(tx_last);
        end
        stall_p = tx_vld && !tx_rdy; d_p = tx_data; l_p = tx_last;

        if (ack_p && reg_req) ack_drop_err++;
        if (rq_p && !ack_p && reg_req && (reg_addr !== a_p || reg_we !== we_p || reg_wdata !== wd_p))
          reg_hold_err++;
        if (reg_req && !rq_p) begin
          acc_log.push_back({reg_we, reg_addr, reg_wdata});
          wcnt = 0;
          cur_dly = (ack_dly != 0) ? ack_dly : int'($urandom_range(1, 4));
        end
        if (reg_req) run++;
        else if (rq_p) begin last_run = run; run = 0; end
        reg_ack = 1'b0;
        reg_rdata = 16'($urandom);
        if (reg_req && !ack_p) begin
          wcnt++;
          if (ack_en && wcnt >= cur_dly) begin
            reg_ack = 1'b1;
            if (!reg_we) reg_rdata = mem[reg_addr[7:0]];
          end
        end
        ack_p = reg_ack; rq_p = reg_req; a_p = reg_addr; we_p = reg_we; wd_p = reg_wdata;
      end
    end
  end

  task automatic do_req(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                        input bit to, input bit drop);
    logic [7:0] exp_b[$];
    logic [15:0] w;
    int exc, exp_acc, gb, ab, th, rh, ad, cyc;
    bit dropped;
    exc = 0;
    if (fc != 8'h03 && fc != 8'h06) exc = 1;
    else if (fc == 8'h03) begin
      if (d == 0 || int'(d) > MAX_QTY) exc = 3;
      else if (int'(a) < BASE || (int'(a) - BASE) + int'(d) > REG_NUM) exc = 2;
    end else if (int'(a) < BASE || int'(a) - BASE >= REG_NUM) exc = 2;
    if (exc == 0 && to) exc = 4;

    if (exc != 0) begin
`ifdef MODBUS_EXCEPTION_EN
      exp_b.push_back(dev_addr); exp_b.push_back(fc | 8'h80); exp_b.push_back(8'(exc));
`endif
    end else if (fc == 8'h03) begin
      exp_b.push_back(dev_addr); exp_b.push_back(8'h03); exp_b.push_back(8'(2 * int'(d)));
      for (int k = 0; k < int'(d); k++) begin
        w = mem[8'(int'(a) + k)];
        exp_b.push_back(w[15:8]); exp_b.push_back(w[7:0]);
      end
    end else begin
      exp_b.push_back(dev_addr); exp_b.push_back(8'h06);
      exp_b.push_back(a[15:8]); exp_b.push_back(a[7:0]);
      exp_b.push_back(d[15:8]); exp_b.push_back(d[7:0]);
    end
    exp_acc = (exc == 0) ? ((fc == 8'h03) ? int'(d) : 1) : ((exc == 4) ? 1 : 0);

    gb = got_q.size(); ab = acc_log.size();
    th = tx_hold_err; rh = reg_hold_err; ad = ack_drop_err;
    ack_en = !to;
    func_code = fc; addr = a; data = d; rx_message_done = 1'b1;
    @(negedge clk_in);
    rx_message_done = 1'b0;
    chk("busy_n1", 32'(req_busy), 32'd1);
    @(negedge clk_in);
    if (exc != 0 && exc != 4) begin
`ifdef MODBUS_EXCEPTION_EN
      chk("exc_first_vld", 32'(tx_vld), 32'd1);
      chk("exc_first_byte", 32'(tx_data), 32'(dev_addr));
`else
      chk("exc_busy_low", 32'(req_busy), 32'd0);
      chk("exc_no_vld", 32'(tx_vld), 32'd0);
`endif
      chk("exc_no_req", 32'(reg_req), 32'd0);
    end else begin
      chk("first_req", 32'(reg_req), 32'd1);
      chk("first_addr", 32'(reg_addr), 32'(a));
    end

    cyc = 0; dropped = 0;
    while (req_busy && cyc < 3000) begin
      if (drop && !dropped && tx_vld) begin
        func_code = 8'($urandom); addr = 16'($urandom); rx_message_done = 1'b1;
        @(negedge clk_in);
        rx_message_done = 1'b0;
        chk("req_drop_pulse", 32'(req_drop), 32'd1);
        dropped = 1;
      end else @(negedge clk_in);
      cyc++;
    end
    chk("done_in_time", 32'(cyc < 3000), 32'd1);
    if (drop && exp_b.size() > 0) chk("drop_seen", 32'(dropped), 32'd1);
    chk("end_vld_low", 32'(tx_vld), 32'd0);
    chk("end_busy_low", 32'(req_busy), 32'd0);
    chk("exc_code", 32'(exc_code), 32'(exc));
    chk("byte_count", 32'(got_q.size() - gb), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && gb + i < got_q.size(); i++) begin
      chk("tx_byte", 32'(got_q[gb + i]), 32'(exp_b[i]));
      chk("tx_last_flag", 32'(got_last_q[gb + i]), 32'(i == exp_b.size() - 1));
    end
    chk("acc_count", 32'(acc_log.size() - ab), 32'(exp_acc));
    for (int k = 0; k < exp_acc && ab + k < acc_log.size(); k++) begin
      chk("acc_we", 32'(acc_log[ab + k][32]), 32'(fc == 8'h06));
      chk("acc_addr", 32'(acc_log[ab + k][31:16]), 32'(16'(int'(a) + k)));
      if (fc == 8'h06) chk("acc_wdata", 32'(acc_log[ab + k][15:0]), 32'(d));
    end
    if (to) chk("timeout_len", 32'(last_run), 32'(ACK_TO));
    chk("tx_hold", 32'(tx_hold_err - th), 32'd0);
    chk("reg_hold", 32'(reg_hold_err - rh), 32'd0);
    chk("req_drop_after_ack", 32'(ack_drop_err - ad), 32'd0);
    ack_en = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    int cyc;
    logic [7:0] fc;
    logic [15:0] a, d;
    rst_n_in = 1'b0; rx_message_done = 1'b0; func_code = 8'h0; addr = 16'h0; data = 16'h0;
    dev_addr = 8'h11; rdy_rand = 0; ack_en = 1; ack_dly = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk_in);
    chk("rst_busy", 32'(req_busy), 0);  chk("rst_drop", 32'(req_drop), 0);
    chk("rst_req", 32'(reg_req), 0);    chk("rst_we", 32'(reg_we), 0);
    chk("rst_addr", 32'(reg_addr), 0);  chk("rst_wdata", 32'(reg_wdata), 0);
    chk("rst_tx_data", 32'(tx_data), 0); chk("rst_tx_vld", 32'(tx_vld), 0);
    chk("rst_tx_last", 32'(tx_last), 0); chk("rst_exc", 32'(exc_code), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    mem[2] = 16'h1234; mem[3] = 16'hABCD;
    do_req(8'h03, 16'h0002, 16'd2, 0, 0);
    rdy_rand = 1; ack_dly = 3;
    do_req(8'h06, 16'h0005, 16'hBEEF, 0, 0);
    rdy_rand = 0; ack_dly = 0;
    do_req(8'h10, 16'h0000, 16'd1, 0, 0);
    do_req(8'h03, 16'h0000, 16'd0, 0, 0);
    do_req(8'h03, 16'h0000, 16'd9, 0, 0);
    do_req(8'h03, 16'h000F, 16'd2, 0, 0);
    do_req(8'h03, 16'hFFFF, 16'd2, 0, 0);
    do_req(8'h06, 16'h0010, 16'h5A5A, 0, 0);
    do_req(8'h06, 16'h000F, 16'hA5A5, 0, 0);
    do_req(8'h03, 16'h0008, 16'd8, 0, 0);
    do_req(8'h03, 16'h0000, 16'd8, 0, 0);
    do_req(8'h03, 16'h0000, 16'd2, 1, 0);
    do_req(8'h06, 16'h0001, 16'h1111, 1, 0);
    rdy_rand = 1;
    do_req(8'h03, 16'h0004, 16'd4, 0, 1);

    // Reset in the middle of a response.
    func_code = 8'h03; addr = 16'h0000; data = 16'd8; rx_message_done = 1'b1;
    @(negedge clk_in);
    rx_message_done = 1'b0;
    cyc = 0;
    while (!tx_vld && cyc < 500) begin @(negedge clk_in); cyc++; end
    chk("midrst_reached_tx", 32'(tx_vld), 32'd1);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_busy", 32'(req_busy), 0); chk("midrst_vld", 32'(tx_vld), 0);
    chk("midrst_req", 32'(reg_req), 0);   chk("midrst_data", 32'(tx_data), 0);
    chk("midrst_last", 32'(tx_last), 0);  chk("midrst_exc", 32'(exc_code), 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    rdy_rand = 0;
    do_req(8'h03, 16'h0001, 16'd3, 0, 0);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: fc = 8'h03;
        1: fc = 8'h06;
        2: fc = 8'h10;
        default: fc = 8'($urandom);
      endcase
      a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      d = (fc == 8'h06) ? 16'($urandom) : 16'($urandom_range(0, 10));
      dev_addr = 8'($urandom);
      rdy_rand = 1'($urandom_range(0, 1));
      do_req(fc, a, d, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
